mem_wb: RTL and testbench

Writeback stage that sits directly upstream of the register file. It accepts completed instructions from the memory stage over a valid/ready handshake and completes loads when data memory returns read data, sign- or zero-extending each load by funct3. It drives the register file's single write port through registered `wb_we`/`wb_waddr`/`wb_wdata` outputs and publishes the pending load destination so decode can stall load-use hazards.

---
 rtl/mem_wb_if.sv | 31 +++
 rtl/mem_wb.sv | 171 +++++++++++++++++
 tb/tb_mem_wb.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_wb_if.sv
// mem_wb_if: memory-stage to writeback-stage instruction handshake.
// The memory stage drives the master side; writeback is the slave.
interface mem_wb_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_wreg;
  logic [4:0]  in_rd;
  logic        in_is_load;
  logic [2:0]  in_funct3;
  logic [31:0] in_data;

  modport master (
    output in_valid,
    output in_wreg,
    output in_rd,
    output in_is_load,
    output in_funct3,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_wreg,
    input  in_rd,
    input  in_is_load,
    input  in_funct3,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/mem_wb.sv
// mem_wb: writeback stage feeding the register-file write port.
// Optional load-data timeout is built when WB_LOAD_TIMEOUT_EN is defined.
module mem_wb #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  mem_wb_if.slave     up,
  input  logic        dmem_valid,
  input  logic [31:0] dmem_rdata,
  output logic        wb_we,
  output logic [4:0]  wb_waddr,
  output logic [31:0] wb_wdata,
  output logic        pend_valid,
  output logic [4:0]  pend_rd,
  output logic        load_err
);

  typedef enum logic {
    IDLE,
    WAIT_MEM
  } state_t;

  state_t      state, state_n;
  logic        ld_wreg, ld_wreg_n;
  logic [4:0]  ld_rd, ld_rd_n;
  logic [2:0]  ld_f3, ld_f3_n;
  logic [1:0]  ld_off, ld_off_n;
  logic        we_n;
  logic [4:0]  waddr_n;
  logic [31:0] wdata_n;
  logic        take;

`ifdef WB_LOAD_TIMEOUT_EN
  logic [7:0]  cnt, cnt_n;
  logic        err_n;
`endif

  // Extract and extend the addressed byte/half of the read word.
  function automatic logic [31:0] fmt(
    input logic [2:0]  f3,
    input logic [1:0]  off,
    input logic [31:0] d
  );
    logic [7:0]  b;
    logic [15:0] h;
    unique case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    unique case (f3)
      3'b000:  fmt = {{24{b[7]}}, b};
      3'b100:  fmt = {24'b0, b};
      3'b001:  fmt = {{16{h[15]}}, h};
      3'b101:  fmt = {16'b0, h};
      default: fmt = d;
    endcase
  endfunction

  assign up.in_ready = rdy && (state == IDLE);
  assign take = up.in_valid && (state == IDLE);

  assign pend_valid = (state == WAIT_MEM) && ld_wreg
                      && (ld_rd != 5'd0);
  assign pend_rd = pend_valid ? ld_rd : 5'd0;

  // Next state, load latches and next write-port values.
  always_comb begin
    state_n   = state;
    ld_wreg_n = ld_wreg;
    ld_rd_n   = ld_rd;
    ld_f3_n   = ld_f3;
    ld_off_n  = ld_off;
    we_n      = 1'b0;
    waddr_n   = wb_waddr;
    wdata_n   = wb_wdata;
`ifdef WB_LOAD_TIMEOUT_EN
    cnt_n     = cnt;
    err_n     = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (take && up.in_is_load) begin
          ld_wreg_n = up.in_wreg;
          ld_rd_n   = up.in_rd;
          ld_f3_n   = up.in_funct3;
          ld_off_n  = up.in_data[1:0];
          state_n   = WAIT_MEM;
`ifdef WB_LOAD_TIMEOUT_EN
          cnt_n     = 8'd0;
`endif
        end else if (take) begin
          we_n    = up.in_wreg && (up.in_rd != 5'd0);
          waddr_n = up.in_rd;
          wdata_n = up.in_data;
        end
      end
      default: begin
        if (dmem_valid) begin
          we_n    = ld_wreg && (ld_rd != 5'd0);
          waddr_n = ld_rd;
          wdata_n = fmt(ld_f3, ld_off, dmem_rdata);
          state_n = IDLE;
        end
`ifdef WB_LOAD_TIMEOUT_EN
        else if (cnt + 8'd1 == 8'(TIMEOUT_CYCLES)) begin
          cnt_n   = cnt + 8'd1;
          we_n    = ld_wreg && (ld_rd != 5'd0);
          waddr_n = ld_rd;
          wdata_n = 32'd0;
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 8'd1;
        end
`endif
      end
    endcase
  end

  // State register; rdy low freezes the FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else if (rdy)
      state <= state_n;
  end

  // Write port and load latches, frozen while rdy is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ld_wreg  <= 1'b0;
      ld_rd    <= 5'd0;
      ld_f3    <= 3'd0;
      ld_off   <= 2'd0;
      wb_we    <= 1'b0;
      wb_waddr <= 5'd0;
      wb_wdata <= 32'd0;
    end else if (rdy) begin
      ld_wreg  <= ld_wreg_n;
      ld_rd    <= ld_rd_n;
      ld_f3    <= ld_f3_n;
      ld_off   <= ld_off_n;
      wb_we    <= we_n;
      wb_waddr <= waddr_n;
      wb_wdata <= wdata_n;
    end
  end

`ifdef WB_LOAD_TIMEOUT_EN
  // Wait counter and one-cycle error pulse for abandoned loads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt      <= 8'd0;
      load_err <= 1'b0;
    end else if (rdy) begin
      cnt      <= cnt_n;
      load_err <= err_n;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = ^TIMEOUT_CYCLES;
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: scoreboard bench for the writeback stage.
// Define WB_LOAD_TIMEOUT_EN to also exercise the load timeout.
module tb_mem_wb;

`ifdef WB_LOAD_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic        clk;
  logic        rst;
  logic        rdy;
  logic        dmem_valid;
  logic [31:0] dmem_rdata;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        pend_valid;
  logic [4:0]  pend_rd;
  logic        load_err;

  mem_wb_if up ();

  mem_wb #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .up         (up.slave),
    .dmem_valid (dmem_valid),
    .dmem_rdata (dmem_rdata),
    .wb_we      (wb_we),
    .wb_waddr   (wb_waddr),
    .wb_wdata   (wb_wdata),
    .pend_valid (pend_valid),
    .pend_rd    (pend_rd),
    .load_err   (load_err)
  );

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    logic        e;
  } wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [4:0] a,
                      input logic [31:0] d,
                      input logic e);
    wr_t w;
    w.a = a;
    w.d = d;
    w.e = e;
    sb.push_back(w);
  endtask

  // A write commits at a rising edge with rdy high.
  always @(negedge clk) begin
    if (!rst && rdy && wb_we) begin
      wr_t w;
      chk("sb_pending", 32'(sb.size() > 0), 32'd1);
      chk("x0_guard", 32'(wb_waddr != 5'd0), 32'd1);
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("wr_addr", 32'(wb_waddr), 32'(w.a));
        chk("wr_data", wb_wdata, w.d);
        chk("wr_err", 32'(load_err), 32'(w.e));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and hold it until accepted.
  task automatic issue(input logic        wreg,
                       input logic [4:0]  rd,
                       input logic        ld,
                       input logic [2:0]  f3,
                       input logic [31:0] data);
    int n;
    up.in_valid   = 1'b1;
    up.in_wreg    = wreg;
    up.in_rd      = rd;
    up.in_is_load = ld;
    up.in_funct3  = f3;
    up.in_data    = data;
    n = 0;
    while (!up.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_to", 32'(n < 50), 32'd1);
    if (!ld && wreg && rd != 5'd0)
      push(rd, data, 1'b0);
    tick();
    up.in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [4:0]  rd,
                         input logic [2:0]  f3,
                         input logic [31:0] addr,
                         input logic [31:0] rdata,
                         input int          dly,
                         input logic [31:0] exp,
                         input logic        early);
    dmem_valid = early;
    dmem_rdata = 32'hBAD0_BAD0;
    issue(1'b1, rd, 1'b1, f3, addr);
    dmem_valid = 1'b0;
    chk("ld_pend", 32'(pend_valid), 32'(rd != 5'd0));
    chk("ld_pend_rd", 32'(pend_rd), 32'(rd));
    chk("ld_busy", 32'(up.in_ready), 32'd0);
    repeat (dly - 1) tick();
    dmem_valid = 1'b1;
    dmem_rdata = rdata;
    if (rd != 5'd0)
      push(rd, exp, 1'b0);
    tick();
    dmem_valid = 1'b0;
    dmem_rdata = 32'hBAD0_BAD0;
    chk("ld_we", 32'(wb_we), 32'(rd != 5'd0));
    chk("ld_in_ready", 32'(up.in_ready), 32'd1);
    chk("ld_pend_clr", 32'(pend_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1);
  end

  initial begin
    rst           = 1'b1;
    rdy           = 1'b1;
    dmem_valid    = 1'b0;
    dmem_rdata    = 32'd0;
    up.in_valid   = 1'b0;
    up.in_wreg    = 1'b0;
    up.in_rd      = 5'd0;
    up.in_is_load = 1'b0;
    up.in_funct3  = 3'd0;
    up.in_data    = 32'd0;
    #12;
    chk("rst_we", 32'(wb_we), 32'd0);
    chk("rst_waddr", 32'(wb_waddr), 32'd0);
    chk("rst_wdata", wb_wdata, 32'd0);
    chk("rst_pend", 32'(pend_valid), 32'd0);
    chk("rst_pend_rd", 32'(pend_rd), 32'd0);
    chk("rst_err", 32'(load_err), 32'd0);
    rst = 1'b0;
    chk("rst_in_ready", 32'(up.in_ready), 32'd1);
    tick();

    issue(1'b1, 5'd5, 1'b0, 3'd0, 32'h11);
    chk("b2b_we0", 32'(wb_we), 32'd1);
    chk("b2b_addr0", 32'(wb_waddr), 32'd5);
    chk("b2b_ready", 32'(up.in_ready), 32'd1);
    issue(1'b1, 5'd6, 1'b0, 3'd0, 32'h22);
    chk("b2b_we1", 32'(wb_we), 32'd1);
    chk("b2b_addr1", 32'(wb_waddr), 32'd6);

    issue(1'b1, 5'd0, 1'b0, 3'd0, 32'h33);
    chk("x0_no_we", 32'(wb_we), 32'd0);
    issue(1'b0, 5'd3, 1'b0, 3'd0, 32'h44);
    chk("nowreg_we", 32'(wb_we), 32'd0);

    do_load(5'd7, 3'b000, 32'h1003, 32'h80FF_FF12, 3,
            32'hFFFF_FF80, 1'b0);
    do_load(5'd8, 3'b101, 32'h2002, 32'hBEEF_0001, 1,
            32'h0000_BEEF, 1'b1);
    do_load(5'd0, 3'b010, 32'h2004, 32'h1234_5678, 2,
            32'h0, 1'b0);
    do_load(5'd13, 3'b100, 32'h1001, 32'h1234_8056, 1,
            32'h0000_0080, 1'b0);
    do_load(5'd14, 3'b001, 32'h0003, 32'h8001_0000, 2,
            32'hFFFF_8001, 1'b0);
    do_load(5'd15, 3'b011, 32'h0001, 32'hDEAD_BEEF, 1,
            32'hDEAD_BEEF, 1'b0);
    do_load(5'd16, 3'b000, 32'h0000, 32'h0000_007F, 1,
            32'h0000_007F, 1'b0);

    issue(1'b1, 5'd10, 1'b0, 3'd0, 32'hAAAA_5555);
    rdy           = 1'b0;
    up.in_valid   = 1'b1;
    up.in_wreg    = 1'b1;
    up.in_rd      = 5'd11;
    up.in_is_load = 1'b1;
    up.in_funct3  = 3'b010;
    up.in_data    = 32'h3000;
    dmem_valid    = 1'b1;
    dmem_rdata    = 32'h0BAD_0BAD;
    repeat (4) begin
      tick();
      chk("hold_we", 32'(wb_we), 32'd1);
      chk("hold_addr", 32'(wb_waddr), 32'd10);
      chk("hold_ready", 32'(up.in_ready), 32'd0);
    end
    rdy        = 1'b1;
    dmem_valid = 1'b0;
    tick();
    up.in_valid = 1'b0;
    chk("frz_pend", 32'(pend_valid), 32'd1);
    chk("frz_we_clr", 32'(wb_we), 32'd0);
    rdy        = 1'b0;
    dmem_valid = 1'b1;
    repeat (3) tick();
    chk("frz_dmem_ign", 32'(pend_valid), 32'd1);
    rdy        = 1'b1;
    dmem_valid = 1'b0;
    tick();
    chk("frz_still", 32'(pend_rd), 32'd11);
    dmem_valid = 1'b1;
    dmem_rdata = 32'h1111_2222;
    push(5'd11, 32'h1111_2222, 1'b0);
    tick();
    dmem_valid = 1'b0;
    chk("frz_ld_we", 32'(wb_we), 32'd1);

`ifdef WB_LOAD_TIMEOUT_EN
    begin
      int n;
      issue(1'b1, 5'd9, 1'b1, 3'b010, 32'h40);
      push(5'd9, 32'd0, 1'b1);
      n = 0;
      while (pend_valid && n < 20) begin
        tick();
        n++;
      end
      chk("to_cycles", 32'(n), 32'd4);
      chk("to_err", 32'(load_err), 32'd1);
      tick();
      chk("to_err_pulse", 32'(load_err), 32'd0);
    end
`endif

    issue(1'b1, 5'd12, 1'b1, 3'b000, 32'h50);
    tick();
    chk("mid_pend", 32'(pend_valid), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_we", 32'(wb_we), 32'd0);
    chk("mrst_waddr", 32'(wb_waddr), 32'd0);
    chk("mrst_wdata", wb_wdata, 32'd0);
    chk("mrst_pend", 32'(pend_valid), 32'd0);
    chk("mrst_pend_rd", 32'(pend_rd), 32'd0);
    chk("mrst_err", 32'(load_err), 32'd0);
    #2;
    rst = 1'b0;
    chk("mrst_ready", 32'(up.in_ready), 32'd1);
    tick();

    issue(1'b1, 5'd20, 1'b0, 3'd0, 32'h5A5A_0000);
    repeat (3) tick();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
